// File: rtl/wash_pkg.sv
// Shared phase codes, default phase lengths and mode/phase helpers
// for the washing-machine programme sequencer.
package wash_pkg;

    localparam logic [2:0] PH_IDLE  = 3'd0;
    localparam logic [2:0] PH_WASH  = 3'd1;
    localparam logic [2:0] PH_RINSE = 3'd2;
    localparam logic [2:0] PH_SPIN  = 3'd3;
    localparam logic [2:0] PH_DONE  = 3'd4;

    localparam logic [7:0] WASH_T_DEF  = 8'd20;
    localparam logic [7:0] RINSE_T_DEF = 8'd10;
    localparam logic [7:0] SPIN_T_DEF  = 8'd6;

    // Mask bits are {wash, rinse, spin}.
    function automatic logic [2:0] mode_mask(input logic [2:0] mode);
        logic [2:0] m;
        case (mode)
            3'd1:    m = 3'b100;
            3'd2:    m = 3'b110;
            3'd3:    m = 3'b011;
            3'd4:    m = 3'b010;
            3'd5:    m = 3'b001;
            default: m = 3'b111;
        endcase
        return m;
    endfunction

    // From IDLE this yields the first enabled phase.
    function automatic logic [2:0] next_phase(
        input logic [2:0] cur,
        input logic [2:0] mask
    );
        logic [2:0] n;
        n = PH_DONE;
        case (cur)
            PH_IDLE: begin
                if (mask[2])      n = PH_WASH;
                else if (mask[1]) n = PH_RINSE;
                else if (mask[0]) n = PH_SPIN;
            end
            PH_WASH: begin
                if (mask[1])      n = PH_RINSE;
                else if (mask[0]) n = PH_SPIN;
            end
            PH_RINSE: begin
                if (mask[0])      n = PH_SPIN;
            end
            default: n = PH_DONE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/wash_sequencer_phase_timer.sv
// Loadable 8-bit down counter timing the current phase.
// Clear beats load beats decrement; it never wraps below zero.
module phase_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       load_i,
    input  logic [7:0] val_i,
    input  logic       dec_i,
    output logic [7:0] count_o,
    output logic       zero_next_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = 8'd0;
        else if (load_i)
            cnt_d = val_i;
        else if (dec_i && cnt_q != 8'd0)
            cnt_d = cnt_q - 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= 8'd0;
        else
            cnt_q <= cnt_d;
    end

    assign count_o     = cnt_q;
    assign zero_next_o = (cnt_q == 8'd1);

endmodule

// File: rtl/wash_sequencer.sv
// Programme sequencer: IDLE -> enabled WASH/RINSE/SPIN phases -> DONE,
// with pause/resume, power-off abort and registered actuator enables.
module wash_sequencer
    import wash_pkg::*;
#(
    parameter logic [7:0] WASH_T  = WASH_T_DEF,
    parameter logic [7:0] RINSE_T = RINSE_T_DEF,
    parameter logic [7:0] SPIN_T  = SPIN_T_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       power_led,
    input  logic       start_pause,
    input  logic [2:0] model_now,
    input  logic       tick_1s,
    output logic [2:0] phase,
    output logic [7:0] time_left,
    output logic       paused,
    output logic       water_valve,
    output logic       motor_on,
    output logic       spin_fast,
    output logic       drain_valve,
    output logic       if_finish
);

    logic [2:0] phase_q, phase_d;
    logic [2:0] mode_q, mode_d;
    logic       paused_q, paused_d;
    logic       fin_q, fin_d;
    logic       water_q, water_d;
    logic       motor_q, motor_d;
    logic       spin_q, spin_d;
    logic       t_clr, t_load, t_dec, t_zero_next;
    logic [7:0] t_val, t_count;

    function automatic logic [7:0] phase_len(input logic [2:0] ph);
        logic [7:0] l;
        case (ph)
            PH_WASH:  l = WASH_T;
            PH_RINSE: l = RINSE_T;
            PH_SPIN:  l = SPIN_T;
            default:  l = 8'd0;
        endcase
        return l;
    endfunction

    always_comb begin
        phase_d  = phase_q;
        mode_d   = mode_q;
        paused_d = paused_q;
        fin_d    = 1'b0;
        t_clr    = 1'b0;
        t_load   = 1'b0;
        t_dec    = 1'b0;
        t_val    = 8'd0;
        if (!power_led) begin
            phase_d  = PH_IDLE;
            paused_d = 1'b0;
            t_clr    = 1'b1;
        end else begin
            unique case (phase_q)
                PH_IDLE: begin
                    if (start_pause) begin
                        mode_d  = model_now;
                        phase_d = next_phase(PH_IDLE,
                                             mode_mask(model_now));
                        t_load  = 1'b1;
                        t_val   = phase_len(phase_d);
                    end
                end
                PH_WASH, PH_RINSE, PH_SPIN: begin
                    // A start_pause always swallows a same-cycle tick.
                    if (start_pause) begin
                        paused_d = !paused_q;
                    end else if (tick_1s && !paused_q) begin
                        if (t_zero_next) begin
                            phase_d = next_phase(phase_q,
                                                 mode_mask(mode_q));
                            if (phase_d == PH_DONE) begin
                                t_clr = 1'b1;
                                fin_d = 1'b1;
                            end else begin
                                t_load = 1'b1;
                                t_val  = phase_len(phase_d);
                            end
                        end else begin
                            t_dec = 1'b1;
                        end
                    end
                end
                default: begin
                    phase_d  = PH_IDLE;
                    paused_d = 1'b0;
                    t_clr    = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        water_d = (phase_d == PH_WASH || phase_d == PH_RINSE)
                  && !paused_d;
        motor_d = (phase_d == PH_WASH || phase_d == PH_RINSE ||
                   phase_d == PH_SPIN) && !paused_d;
        spin_d  = (phase_d == PH_SPIN) && !paused_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q  <= PH_IDLE;
            mode_q   <= 3'd0;
            paused_q <= 1'b0;
            fin_q    <= 1'b0;
            water_q  <= 1'b0;
            motor_q  <= 1'b0;
            spin_q   <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            mode_q   <= mode_d;
            paused_q <= paused_d;
            fin_q    <= fin_d;
            water_q  <= water_d;
            motor_q  <= motor_d;
            spin_q   <= spin_d;
        end
    end

    phase_timer u_timer (
        .clk         (clk),
        .rst_n       (reset),
        .clr_i       (t_clr),
        .load_i      (t_load),
        .val_i       (t_val),
        .dec_i       (t_dec),
        .count_o     (t_count),
        .zero_next_o (t_zero_next)
    );

    assign phase       = phase_q;
    assign time_left   = t_count;
    assign paused      = paused_q;
    assign water_valve = water_q;
    assign motor_on    = motor_q;
    assign spin_fast   = spin_q;
    assign drain_valve = spin_q;
    assign if_finish   = fin_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// Self-checking bench for wash_sequencer with short phase lengths.
// A queue-based programme model predicts every output each cycle.
module tb_wash_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       power_led = 1'b0;
    logic       start_pause = 1'b0;
    logic [2:0] model_now = 3'd0;
    logic       tick_1s = 1'b0;
    logic [2:0] phase;
    logic [7:0] time_left;
    logic       paused, water_valve, motor_on;
    logic       spin_fast, drain_valve, if_finish;

    int errors = 0;
    int checks = 0;

    wash_sequencer #(
        .WASH_T  (8'd3),
        .RINSE_T (8'd2),
        .SPIN_T  (8'd2)
    ) dut (
        .clk         (clk),
        .reset       (rst_n),
        .power_led   (power_led),
        .start_pause (start_pause),
        .model_now   (model_now),
        .tick_1s     (tick_1s),
        .phase       (phase),
        .time_left   (time_left),
        .paused      (paused),
        .water_valve (water_valve),
        .motor_on    (motor_on),
        .spin_fast   (spin_fast),
        .drain_valve (drain_valve),
        .if_finish   (if_finish)
    );

    always #5 clk = ~clk;

    wire [16:0] dut_vec = {phase, time_left, paused, water_valve,
                           motor_on, spin_fast, drain_valve, if_finish};

    // Reference model: programme = queue of phases still to run.
    int m_phase, m_left, m_mode;
    bit m_paused, m_fin;
    int m_plan[$];
    int mask_tab[8] = '{7, 4, 6, 3, 2, 1, 7, 7};

    function automatic int plen(input int p);
        return (p == 1) ? 3 : 2;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_left = 0; m_mode = 0;
        m_paused = 0; m_fin = 0;
        m_plan.delete();
    endtask

    task automatic model_step(input bit p, input bit s,
                              input bit t, input int mn);
        m_fin = 0;
        if (!p) begin
            m_phase = 0; m_left = 0; m_paused = 0;
            m_plan.delete();
        end else if (m_phase == 0) begin
            if (s) begin
                m_mode = mn;
                m_plan.delete();
                if (mask_tab[mn] & 4) m_plan.push_back(1);
                if (mask_tab[mn] & 2) m_plan.push_back(2);
                if (mask_tab[mn] & 1) m_plan.push_back(3);
                m_phase = m_plan.pop_front();
                m_left = plen(m_phase);
            end
        end else if (m_phase == 4) begin
            m_phase = 0;
        end else begin
            if (s) m_paused = !m_paused;
            else if (t && !m_paused) begin
                if (m_left == 1) begin
                    if (m_plan.size() > 0) begin
                        m_phase = m_plan.pop_front();
                        m_left = plen(m_phase);
                    end else begin
                        m_phase = 4; m_left = 0; m_fin = 1;
                    end
                end else m_left = m_left - 1;
            end
        end
    endtask

    function automatic logic [16:0] exp_vec();
        logic w, m, sp;
        w  = (m_phase == 1 || m_phase == 2) && !m_paused;
        m  = (m_phase >= 1 && m_phase <= 3) && !m_paused;
        sp = (m_phase == 3) && !m_paused;
        return {3'(m_phase), 8'(m_left), m_paused, w, m, sp, sp, m_fin};
    endfunction

    task automatic cycle(input bit p, input bit s,
                         input bit t, input logic [2:0] mn);
        power_led = p; start_pause = s;
        tick_1s = t; model_now = mn;
        @(posedge clk);
        model_step(p, s, t, int'(mn));
        #1;
        start_pause = 1'b0;
        tick_1s = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec !== 17'd0) begin
            errors++;
            $display("FAIL reset_state got %h want %h", dut_vec, 17'd0);
        end
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        cycle(1, 0, 0, 0);
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL idle_after_reset got %h want %h",
                     dut_vec, exp_vec());
        end
    endtask

    task automatic test_full_run();
        int exp_ph[8] = '{1, 1, 1, 2, 2, 3, 3, 4};
        cycle(1, 1, 0, 0);
        checks++;
        if (phase !== 3'd1 || time_left !== 8'd3) begin
            errors++;
            $display("FAIL mode0_start got %0d/%0d want 1/3",
                     phase, time_left);
        end
        for (int i = 1; i < 8; i++) begin
            cycle(1, 0, 1, 0);
            checks++;
            if (phase !== 3'(exp_ph[i]) || dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL mode0_tick%0d got ph=%0d vec=%h want ph=%0d vec=%h",
                         i, phase, dut_vec, exp_ph[i], exp_vec());
            end
        end
        checks++;
        if (if_finish !== 1'b1) begin
            errors++;
            $display("FAIL mode0_finish got %b want 1", if_finish);
        end
        cycle(1, 0, 0, 0);
        checks++;
        if (phase !== 3'd0 || if_finish !== 1'b0) begin
            errors++;
            $display("FAIL mode0_back_idle got ph=%0d fin=%b want 0/0",
                     phase, if_finish);
        end
    endtask

    task automatic test_mode5();
        cycle(1, 1, 0, 5);
        checks++;
        if (phase !== 3'd3 || time_left !== 8'd2 || water_valve !== 1'b0) begin
            errors++;
            $display("FAIL mode5_start got %0d/%0d/%b want 3/2/0",
                     phase, time_left, water_valve);
        end
        for (int i = 0; i < 2; i++) begin
            cycle(1, 0, 1, 5);
            checks++;
            if (water_valve !== 1'b0 || dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL mode5_tick%0d got %h want %h",
                         i, dut_vec, exp_vec());
            end
        end
        checks++;
        if (if_finish !== 1'b1 || phase !== 3'd4) begin
            errors++;
            $display("FAIL mode5_finish got fin=%b ph=%0d want 1/4",
                     if_finish, phase);
        end
        cycle(1, 0, 0, 0);
    endtask

    task automatic test_pause();
        cycle(1, 1, 0, 2);
        cycle(1, 0, 1, 2);
        cycle(1, 1, 0, 2);
        checks++;
        if (paused !== 1'b1 || motor_on !== 1'b0 || time_left !== 8'd2) begin
            errors++;
            $display("FAIL pause_enter got p=%b m=%b t=%0d want 1/0/2",
                     paused, motor_on, time_left);
        end
        for (int i = 0; i < 5; i++) cycle(1, 0, 1, 2);
        checks++;
        if (time_left !== 8'd2 || phase !== 3'd1) begin
            errors++;
            $display("FAIL pause_hold got t=%0d ph=%0d want 2/1",
                     time_left, phase);
        end
        cycle(1, 1, 0, 2);
        checks++;
        if (paused !== 1'b0 || motor_on !== 1'b1 || water_valve !== 1'b1) begin
            errors++;
            $display("FAIL pause_resume got p=%b m=%b w=%b want 0/1/1",
                     paused, motor_on, water_valve);
        end
        cycle(1, 0, 1, 2);
        cycle(1, 0, 1, 2);
        checks++;
        if (phase !== 3'd2 || time_left !== 8'd2) begin
            errors++;
            $display("FAIL pause_advance got ph=%0d t=%0d want 2/2",
                     phase, time_left);
        end
        cycle(0, 0, 0, 0);
    endtask

    task automatic test_power_off();
        cycle(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 0, 1, 5);
        checks++;
        if (phase !== 3'd2 || time_left !== 8'd2) begin
            errors++;
            $display("FAIL mode_change_ignored got ph=%0d t=%0d want 2/2",
                     phase, time_left);
        end
        cycle(0, 0, 1, 5);
        checks++;
        if (dut_vec !== 17'd0) begin
            errors++;
            $display("FAIL power_off got %h want %h", dut_vec, 17'd0);
        end
        cycle(0, 1, 0, 5);
        checks++;
        if (phase !== 3'd0) begin
            errors++;
            $display("FAIL power_off_start got ph=%0d want 0", phase);
        end
    endtask

    task automatic test_async_reset();
        cycle(1, 1, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 0, 1, 0);
        checks++;
        if (phase !== 3'd3 || spin_fast !== 1'b1 || drain_valve !== 1'b1) begin
            errors++;
            $display("FAIL spin_reached got ph=%0d s=%b d=%b want 3/1/1",
                     phase, spin_fast, drain_valve);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec !== 17'd0) begin
            errors++;
            $display("FAIL async_reset got %h want %h", dut_vec, 17'd0);
        end
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        cycle(1, 0, 1, 0);
        cycle(1, 0, 1, 0);
        checks++;
        if (phase !== 3'd0 || time_left !== 8'd0) begin
            errors++;
            $display("FAIL reset_resume got ph=%0d t=%0d want 0/0",
                     phase, time_left);
        end
    endtask

    task automatic test_same_cycle();
        cycle(1, 1, 0, 0);
        cycle(1, 0, 1, 0);
        cycle(1, 1, 1, 0);
        checks++;
        if (paused !== 1'b1 || time_left !== 8'd2) begin
            errors++;
            $display("FAIL same_cycle_pause got p=%b t=%0d want 1/2",
                     paused, time_left);
        end
        cycle(1, 1, 1, 0);
        checks++;
        if (paused !== 1'b0 || time_left !== 8'd2) begin
            errors++;
            $display("FAIL same_cycle_resume got p=%b t=%0d want 0/2",
                     paused, time_left);
        end
        cycle(0, 0, 0, 0);
    endtask

    task automatic test_random();
        bit p, s, t;
        logic [2:0] mn;
        for (int i = 0; i < 600; i++) begin
            p  = ($urandom_range(0, 29) != 0);
            s  = ($urandom_range(0, 5) == 0);
            t  = ($urandom_range(0, 1) == 0);
            mn = 3'($urandom_range(0, 7));
            cycle(p, s, t, mn);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random_cyc%0d got %h want %h",
                         i, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_full_run();
        test_mode5();
        test_pause();
        test_power_off();
        test_async_reset();
        test_same_cycle();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
